// File: rtl/i2c_cmd_arb_if.sv
// Requester and engine handshake bundle for i2c_cmd_arb.
// master = arbiter side, slave = requesters/engine side.
interface i2c_cmd_arb_if;
  logic [1:0] req;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       fail;
  logic       eng_start;
  logic [7:0] eng_data;
  logic       eng_busy;
  logic       eng_done;
  logic       eng_nack;

  modport master (
    input  req, req_data0, req_data1, eng_busy, eng_done, eng_nack,
    output gnt, done, fail, eng_start, eng_data
  );

  modport slave (
    output req, req_data0, req_data1, eng_busy, eng_done, eng_nack,
    input  gnt, done, fail, eng_start, eng_data
  );
endinterface

// File: rtl/i2c_cmd_arb.sv
// Feeds an I2C write engine: boot table first, then round-robin runtime requests,
// reissuing NACKed bytes up to RETRY_MAX times before dropping them.
module i2c_cmd_arb #(
  parameter int unsigned INIT_LEN  = 41,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic          clk2,
  input  logic          reset,
  output logic [6:0]    rom_addr,
  input  logic [7:0]    rom_data,
  i2c_cmd_arb_if.master bus,
  output logic          init_done,
  output logic [3:0]    err_cnt
);

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(INIT_LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);
  localparam logic [ERR_W-1:0]   ERR_SAT   = '1;

  typedef enum logic [1:0] {
    INIT_ISSUE = 2'd0,
    INIT_WAIT  = 2'd1,
    ARB        = 2'd2,
    RUN_WAIT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               last_gnt_q, last_gnt_d;
  logic               owner_q, owner_d;
  logic               reissue_q, reissue_d;

  logic [ADDR_W-1:0]  rom_addr_d;
  logic [DATA_W-1:0]  eng_data_d;
  logic               eng_start_d;
  logic [1:0]         gnt_d;
  logic [1:0]         done_d;
  logic               fail_d;
  logic               init_done_d;
  logic [ERR_W-1:0]   err_cnt_d;

  logic               retry_left;
  logic               init_last;
  logic               req_any;
  logic               pref;
  logic               winner;
  logic [ERR_W-1:0]   err_inc;

  assign retry_left = (retry_q != RETRY_LIM);
  assign init_last  = (rom_addr == LAST_ADDR);
  assign req_any    = |bus.req;
  assign pref       = ~last_gnt_q;
  // The requester that did not win last time has priority if it is asking.
  assign winner     = bus.req[pref] ? pref : ~pref;
  assign err_inc    = (err_cnt == ERR_SAT) ? err_cnt : err_cnt + ERR_W'(1);

  // State register
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) state_q <= INIT_ISSUE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_ISSUE: if (!bus.eng_busy) state_d = INIT_WAIT;
      INIT_WAIT: begin
        if (bus.eng_done) begin
          if (bus.eng_nack && retry_left) state_d = INIT_ISSUE;
          else if (init_last)             state_d = ARB;
          else                            state_d = INIT_ISSUE;
        end
      end
      ARB: if (req_any && !bus.eng_busy) state_d = RUN_WAIT;
      RUN_WAIT: begin
        // While a reissue is pending no transaction is outstanding, so eng_done is stray.
        if (!reissue_q && bus.eng_done && !(bus.eng_nack && retry_left)) state_d = ARB;
      end
      default: state_d = INIT_ISSUE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    rom_addr_d  = rom_addr;
    retry_d     = retry_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    reissue_d   = reissue_q;
    eng_data_d  = bus.eng_data;
    eng_start_d = 1'b0;
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    fail_d      = 1'b0;
    init_done_d = init_done;
    err_cnt_d   = err_cnt;

    case (state_q)
      INIT_ISSUE: begin
        if (!bus.eng_busy) begin
          eng_start_d = 1'b1;
          eng_data_d  = rom_data;
        end
      end
      INIT_WAIT: begin
        if (bus.eng_done) begin
          if (bus.eng_nack && retry_left) begin
            retry_d = retry_q + RETRY_W'(1);
          end else begin
            if (bus.eng_nack) err_cnt_d = err_inc;
            retry_d = '0;
            if (init_last) init_done_d = 1'b1;
            else           rom_addr_d  = rom_addr + ADDR_W'(1);
          end
        end
      end
      ARB: begin
        if (req_any && !bus.eng_busy) begin
          gnt_d       = 2'(2'b01 << winner);
          eng_data_d  = winner ? bus.req_data1 : bus.req_data0;
          eng_start_d = 1'b1;
          last_gnt_d  = winner;
          owner_d     = winner;
          retry_d     = '0;
        end
      end
      RUN_WAIT: begin
        if (reissue_q) begin
          if (!bus.eng_busy) begin
            eng_start_d = 1'b1;
            reissue_d   = 1'b0;
          end
        end else if (bus.eng_done) begin
          if (bus.eng_nack && retry_left) begin
            retry_d   = retry_q + RETRY_W'(1);
            reissue_d = 1'b1;
          end else begin
            done_d  = 2'(2'b01 << owner_q);
            fail_d  = bus.eng_nack;
            retry_d = '0;
            if (bus.eng_nack) err_cnt_d = err_inc;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      rom_addr      <= '0;
      retry_q       <= '0;
      last_gnt_q    <= 1'b1;
      owner_q       <= 1'b0;
      reissue_q     <= 1'b0;
      bus.eng_data  <= '0;
      bus.eng_start <= 1'b0;
      bus.gnt       <= 2'b00;
      bus.done      <= 2'b00;
      bus.fail      <= 1'b0;
      init_done     <= 1'b0;
      err_cnt       <= '0;
    end else begin
      rom_addr      <= rom_addr_d;
      retry_q       <= retry_d;
      last_gnt_q    <= last_gnt_d;
      owner_q       <= owner_d;
      reissue_q     <= reissue_d;
      bus.eng_data  <= eng_data_d;
      bus.eng_start <= eng_start_d;
      bus.gnt       <= gnt_d;
      bus.done      <= done_d;
      bus.fail      <= fail_d;
      init_done     <= init_done_d;
      err_cnt       <= err_cnt_d;
    end
  end

endmodule
